// File: rtl/key_debounce_multi.sv
// Multi-channel active-low push-button debouncer with press/release pulses.
// Optional long-press detection is compiled in when KEY_LONG_PRESS_EN is defined.
module key_debounce_multi #(
  parameter int NUM_KEYS = 4,
  parameter int CNT_MAX  = 20,
  parameter int LONG_MAX = 50_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_filter,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic          meta_r;
    logic          sync_r;
    logic          filter_r;
    logic          press_r;
    logic          release_r;
    logic          long_s;
    logic [CW-1:0] cnt_r;
    logic          accept_s;

    // A new level is taken on the edge where it has differed for CNT_MAX samples.
    assign accept_s = (sync_r != filter_r) && (cnt_r == CNT_TOP);

    // two-flop synchroniser for the asynchronous key pin
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        meta_r <= 1'b1;
        sync_r <= 1'b1;
      end else begin
        meta_r <= key[i];
        sync_r <= meta_r;
      end
    end

    // stability counter, filtered level and edge pulses
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        cnt_r     <= CNT_ZERO;
        filter_r  <= 1'b1;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        if (sync_r == filter_r) begin
          cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
          cnt_r     <= CNT_ZERO;
          filter_r  <= sync_r;
          press_r   <= ~sync_r;
          release_r <= sync_r;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int HW = (LONG_MAX > 1) ? $clog2(LONG_MAX + 1) : 1;
    localparam logic [HW-1:0] HOLD_TOP  = HW'(LONG_MAX);
    localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_MAX - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_ZERO = HW'(0);

    logic [HW-1:0] hcnt_r;
    logic          long_r;

    // Hold counter saturates, so one pulse per press; an accepted release
    // on the saturating edge suppresses the pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        hcnt_r <= HOLD_ZERO;
        long_r <= 1'b0;
      end else if (accept_s || filter_r) begin
        hcnt_r <= HOLD_ZERO;
        long_r <= 1'b0;
      end else if (hcnt_r != HOLD_TOP) begin
        hcnt_r <= hcnt_r + HOLD_ONE;
        long_r <= (hcnt_r == HOLD_PRE);
      end else begin
        hcnt_r <= hcnt_r;
        long_r <= 1'b0;
      end
    end

    assign long_s = long_r;
`else
    assign long_s = 1'b0;
`endif

    assign key_filter[i]  = filter_r;
    assign key_press[i]   = press_r;
    assign key_release[i] = release_r;
    assign key_long[i]    = long_s;
  end

endmodule
